// File: rtl/shape_draw_engine.sv
// Shape draw responder: on draw_start it rasters its rectangle one pixel per clock,
// then holds draw_done until released. It also owns the shape's scrolling origin.
module shape_draw_engine #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned HEIGHT          = 8,
  parameter int unsigned START_X         = 140,
  parameter int unsigned START_Y         = 100,
  parameter int unsigned SPEED           = 4,
  parameter bit          HOLLOW          = 1'b0,
  parameter logic [2:0]  COLOUR          = 3'b111,
  parameter logic [2:0]  INTERIOR_COLOUR = 3'b000,
  parameter bit          SCROLL          = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        draw_start,
  input  logic        move,
  output logic        draw_done,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [2:0]  colour,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_COL  = 8'(WIDTH - 1);
  localparam logic [7:0]  LAST_ROW  = 8'(HEIGHT - 1);
  localparam logic [10:0] START_X_C = 11'(START_X);
  localparam logic [10:0] ORIGIN_Y  = 11'(START_Y);
  localparam logic [10:0] SPEED_C   = 11'(SPEED);

  state_t      state_r, next_state_s;
  logic [7:0]  col_r, row_r;
  logic [10:0] origin_x_r, moved_x_s;
  logic        move_pending_r, pending_next_s, apply_s;
  logic        last_col_s, last_row_s, border_s;
  logic [2:0]  pix_colour_s;
  logic [10:0] x_r, y_r;
  logic [2:0]  colour_r;
  logic        busy_r, done_r;

  assign last_col_s   = (col_r == LAST_COL);
  assign last_row_s   = (row_r == LAST_ROW);
  assign border_s     = (col_r == 8'd0) || last_col_s || (row_r == 8'd0) || last_row_s;
  assign pix_colour_s = (HOLLOW && !border_s) ? INTERIOR_COLOUR : COLOUR;
  assign moved_x_s    = (origin_x_r < SPEED_C) ? START_X_C : (origin_x_r - SPEED_C);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (draw_start) next_state_s = DRAW;
        else            next_state_s = IDLE;
      end
      DRAW: begin
        if (!draw_start)                   next_state_s = IDLE;
        else if (last_col_s && last_row_s) next_state_s = DONE;
        else                               next_state_s = DRAW;
      end
      DONE: begin
        if (draw_start) next_state_s = DONE;
        else            next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Moves seen mid-scan are parked and applied as the scan leaves DRAW
  always_comb begin
    apply_s        = 1'b0;
    pending_next_s = 1'b0;
    if (SCROLL) begin
      if (state_r == DRAW) begin
        if (next_state_s != DRAW) begin
          apply_s        = move || move_pending_r;
          pending_next_s = 1'b0;
        end else begin
          apply_s        = 1'b0;
          pending_next_s = move_pending_r || move;
        end
      end else begin
        apply_s        = move;
        pending_next_s = 1'b0;
      end
    end else begin
      apply_s        = 1'b0;
      pending_next_s = 1'b0;
    end
  end

  // Scroll origin and pending move
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      origin_x_r     <= START_X_C;
      move_pending_r <= 1'b0;
    end else begin
      if (apply_s) origin_x_r <= moved_x_s;
      move_pending_r <= pending_next_s;
    end
  end

  // Raster counters, cleared whenever the scan is not continuing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_r <= 8'd0;
      row_r <= 8'd0;
    end else if ((state_r == DRAW) && (next_state_s == DRAW)) begin
      if (last_col_s) begin
        col_r <= 8'd0;
        row_r <= row_r + 8'd1;
      end else begin
        col_r <= col_r + 8'd1;
      end
    end else begin
      col_r <= 8'd0;
      row_r <= 8'd0;
    end
  end

  // Output registers; DONE freezes the last pixel even if the origin moves
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_r      <= START_X_C;
      y_r      <= ORIGIN_Y;
      colour_r <= COLOUR;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          x_r      <= origin_x_r;
          y_r      <= ORIGIN_Y;
          colour_r <= COLOUR;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
        DRAW: begin
          x_r      <= origin_x_r + {3'b000, col_r};
          y_r      <= ORIGIN_Y + {3'b000, row_r};
          colour_r <= pix_colour_s;
          busy_r   <= 1'b1;
          done_r   <= 1'b0;
        end
        DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign x         = x_r;
  assign y         = y_r;
  assign colour    = colour_r;
  assign busy      = busy_r;
  assign draw_done = done_r;

endmodule

// File: tb/tb_shape_draw_engine.sv
// Bench for shape_draw_engine: three differently configured instances share stimulus
// and are compared each cycle against a pixel-index model, plus directed scenario checks.
module tb_shape_draw_engine;

  localparam int N = 3;
  // instance 0: solid 2x2; 1: hollow 3x3; 2: static 5x2 near the 11-bit edge
  localparam int P_W[N]      = '{2, 3, 5};
  localparam int P_H[N]      = '{2, 3, 2};
  localparam int P_SX[N]     = '{10, 30, 2045};
  localparam int P_SY[N]     = '{20, 40, 2047};
  localparam int P_SP[N]     = '{4, 3, 7};
  localparam int P_HOL[N]    = '{0, 1, 0};
  localparam int P_COL[N]    = '{7, 5, 3};
  localparam int P_INT[N]    = '{0, 2, 0};
  localparam int P_SCR[N]    = '{1, 1, 0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic draw_start = 1'b0;
  logic move = 1'b0;
  logic        done_o[N];
  logic        busy_o[N];
  logic [10:0] x_o[N];
  logic [10:0] y_o[N];
  logic [2:0]  col_o[N];

  int checks_cnt = 0;
  int errors_cnt = 0;

  // model: phase 0 = waiting, 1 = scanning pixel index m_pix, 2 = finished
  int m_phase[N], m_pix[N], m_org[N], m_pend[N];
  int e_x[N], e_y[N], e_c[N], e_busy[N], e_done[N];

  always #5 clock = ~clock;

  shape_draw_engine #(.WIDTH(2), .HEIGHT(2), .START_X(10), .START_Y(20), .SPEED(4),
    .HOLLOW(1'b0), .COLOUR(3'b111), .INTERIOR_COLOUR(3'b000), .SCROLL(1'b1)) dut_a (
    .clock(clock), .reset(reset), .draw_start(draw_start), .move(move),
    .draw_done(done_o[0]), .x(x_o[0]), .y(y_o[0]), .colour(col_o[0]), .busy(busy_o[0]));

  shape_draw_engine #(.WIDTH(3), .HEIGHT(3), .START_X(30), .START_Y(40), .SPEED(3),
    .HOLLOW(1'b1), .COLOUR(3'b101), .INTERIOR_COLOUR(3'b010), .SCROLL(1'b1)) dut_b (
    .clock(clock), .reset(reset), .draw_start(draw_start), .move(move),
    .draw_done(done_o[1]), .x(x_o[1]), .y(y_o[1]), .colour(col_o[1]), .busy(busy_o[1]));

  shape_draw_engine #(.WIDTH(5), .HEIGHT(2), .START_X(2045), .START_Y(2047), .SPEED(7),
    .HOLLOW(1'b0), .COLOUR(3'b011), .INTERIOR_COLOUR(3'b000), .SCROLL(1'b0)) dut_c (
    .clock(clock), .reset(reset), .draw_start(draw_start), .move(move),
    .draw_done(done_o[2]), .x(x_o[2]), .y(y_o[2]), .colour(col_o[2]), .busy(busy_o[2]));

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int moved(input int org, input int sx, input int sp);
    return (org < sp) ? sx : org - sp;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_pix[i] = 0; m_org[i] = P_SX[i]; m_pend[i] = 0;
      e_x[i] = P_SX[i]; e_y[i] = P_SY[i]; e_c[i] = P_COL[i]; e_busy[i] = 0; e_done[i] = 0;
    end
  endtask

  // one clock edge: outputs reflect the pre-edge situation, then advance
  task automatic model_step(input int ds, input int mv);
    for (int i = 0; i < N; i++) begin
      int c, r, total;
      bit mvok;
      total = P_W[i] * P_H[i];
      mvok  = (P_SCR[i] != 0) && (mv != 0);
      if (m_phase[i] == 0) begin
        e_x[i] = m_org[i]; e_y[i] = P_SY[i]; e_c[i] = P_COL[i]; e_busy[i] = 0; e_done[i] = 0;
      end else if (m_phase[i] == 1) begin
        c = m_pix[i] % P_W[i];
        r = m_pix[i] / P_W[i];
        e_x[i] = (m_org[i] + c) % 2048;
        e_y[i] = (P_SY[i] + r) % 2048;
        if (P_HOL[i] != 0 && c > 0 && c < P_W[i] - 1 && r > 0 && r < P_H[i] - 1)
          e_c[i] = P_INT[i];
        else
          e_c[i] = P_COL[i];
        e_busy[i] = 1; e_done[i] = 0;
      end else begin
        e_busy[i] = 0; e_done[i] = 1;
      end
      case (m_phase[i])
        0: begin
          if (mvok) m_org[i] = moved(m_org[i], P_SX[i], P_SP[i]);
          if (ds != 0) begin m_phase[i] = 1; m_pix[i] = 0; end
        end
        1: begin
          if (ds == 0 || m_pix[i] == total - 1) begin
            if (mvok || m_pend[i] != 0) m_org[i] = moved(m_org[i], P_SX[i], P_SP[i]);
            m_pend[i] = 0;
            m_phase[i] = (ds != 0) ? 2 : 0;
          end else begin
            m_pix[i]++;
            if (mvok) m_pend[i] = 1;
          end
        end
        default: begin
          if (mvok) m_org[i] = moved(m_org[i], P_SX[i], P_SP[i]);
          if (ds == 0) m_phase[i] = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("x%0d", i), int'(x_o[i]), e_x[i]);
      check_eq($sformatf("y%0d", i), int'(y_o[i]), e_y[i]);
      check_eq($sformatf("colour%0d", i), int'(col_o[i]), e_c[i]);
      check_eq($sformatf("busy%0d", i), int'(busy_o[i]), e_busy[i]);
      check_eq($sformatf("done%0d", i), int'(done_o[i]), e_done[i]);
    end
  endtask

  task automatic tick(input int ds, input int mv);
    draw_start = (ds != 0);
    move = (mv != 0);
    @(posedge clock);
    model_step(ds, mv);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    int n, first_a, first_b, interior_cnt, hold, ds_lvl;
    int qx[$], qy[$], qc[$];
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    check_eq("rst_x", int'(x_o[0]), 10);
    check_eq("rst_colour", int'(col_o[0]), 7);

    // first scan: latency, raster order, hollow interior
    n = 0; first_a = -1; first_b = -1; interior_cnt = 0;
    while (n < 20 && !(first_a >= 0 && first_b >= 0)) begin
      tick(1, 0);
      n++;
      if (busy_o[0]) begin qx.push_back(int'(x_o[0])); qy.push_back(int'(y_o[0])); qc.push_back(int'(col_o[0])); end
      if (busy_o[1] && col_o[1] == 3'b010) begin
        interior_cnt++;
        check_eq("interior_x", int'(x_o[1]), 31);
        check_eq("interior_y", int'(y_o[1]), 41);
      end
      if (done_o[0] && first_a < 0) first_a = n;
      if (done_o[1] && first_b < 0) first_b = n;
    end
    check_eq("latency_a", first_a - 1, 5);
    check_eq("latency_b", first_b - 1, 10);
    check_eq("pixels_a", qx.size(), 4);
    if (qx.size() == 4) begin
      check_eq("px0", qx[0] * 4096 + qy[0], 10 * 4096 + 20);
      check_eq("px1", qx[1] * 4096 + qy[1], 11 * 4096 + 20);
      check_eq("px2", qx[2] * 4096 + qy[2], 10 * 4096 + 21);
      check_eq("px3", qx[3] * 4096 + qy[3], 11 * 4096 + 21);
      check_eq("pcol3", qc[3], 7);
    end
    check_eq("interior_cnt", interior_cnt, 1);
    for (int k = 0; k < 10; k++) begin
      tick(1, 0);
      check_eq("done_hold", int'(done_o[0]), 1);
    end
    tick(0, 0);
    tick(0, 0);
    check_eq("done_drop", int'(done_o[0]), 0);

    // three moves while idle: 10 -> 6 -> 2 -> wrap to 10
    tick(0, 1);
    tick(0, 1);
    check_eq("move6", int'(x_o[0]), 6);
    tick(0, 1);
    check_eq("move2", int'(x_o[0]), 2);
    tick(0, 0);
    check_eq("move_wrap", int'(x_o[0]), 10);

    // moves mid-scan collapse into one, applied on entering DONE
    tick(1, 0); tick(1, 1); tick(1, 1); tick(1, 0); tick(1, 0);
    check_eq("scan_x_frozen", int'(x_o[0]), 11);
    for (int k = 0; k < 6; k++) tick(1, 0);
    tick(0, 0); tick(0, 0);
    check_eq("after_pending", int'(x_o[0]), 6);

    // abort after two pixels, then restart
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    check_eq("abort_done", int'(done_o[0]), 0);
    check_eq("abort_busy", int'(busy_o[0]), 0);
    tick(1, 0); tick(1, 0);
    check_eq("restart_x", int'(x_o[0]), 6);

    // async reset mid-scan with origin at 6
    tick(1, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("areset_x", int'(x_o[0]), 10);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    tick(0, 0);
    check_eq("post_reset_busy", int'(busy_o[0]), 0);

    // randomized level holds and move pulses
    hold = 0; ds_lvl = 0;
    for (int k = 0; k < 800; k++) begin
      if (hold == 0) begin
        ds_lvl = ($urandom_range(0, 3) != 0) ? 1 : 0;
        hold = $urandom_range(1, 14);
      end
      hold--;
      tick(ds_lvl, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/shape_draw_engine.md
Name: shape_draw_engine

Overview:
- Responder end of the shape draw handshake that the game controller drives.
- One instance per shape: Square_frame, Block, Spike or Black_screen.
- On `draw_start`, the block walks every pixel of its rectangle, presenting `x`, `y` and `colour` one pixel per clock. It then raises `draw_done` and holds it until the controller releases `draw_start`.
- It also owns the shape's scrolling position, which moves on the screen-update pulse.

Parameters:
- WIDTH, 8, rectangle width in pixels (1..255)
- HEIGHT, 8, rectangle height in pixels (1..255)
- START_X, 140, origin x after reset and x reload value on wrap
- START_Y, 100, origin y (fixed)
- SPEED, 4, pixels subtracted from origin x per move pulse
- HOLLOW, 0, 1 = frame mode (border in COLOUR, interior in INTERIOR_COLOUR); 0 = solid
- COLOUR, 3'b111, border/solid colour
- INTERIOR_COLOUR, 3'b000, interior colour in frame mode
- SCROLL, 1, 0 = ignore move (static shape)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; returns the block to its power-on state
- draw_start  in  1  level request from controller; held until draw_done is seen
- move  in  1  one-cycle screen-update pulse
- draw_done  out  1  drawing complete; held while draw_start stays high
- x  out  11  current pixel x
- y  out  11  current pixel y
- colour  out  3  current pixel colour
- busy  out  1  high in DRAW

Behaviour:
- Reset (async, any state):
  - state=IDLE, origin_x=START_X, origin_y=START_Y, col=row=0, move_pending=0.
  - Outputs: draw_done=0, busy=0, x=START_X, y=START_Y, colour=COLOUR.
- States: IDLE, DRAW, DONE.
- IDLE:
  - x=origin_x, y=origin_y.
  - draw_start=1 → DRAW next cycle with col=row=0.
- DRAW:
  - x = origin_x+col, y = origin_y+row. Additions are 11-bit; overflow truncates and is not flagged.
  - busy=1.
  - Each cycle: col+1. When col==WIDTH-1: col=0, row+1.
  - At col==WIDTH-1 and row==HEIGHT-1 → DONE next cycle.
  - Exactly WIDTH*HEIGHT pixel cycles. draw_done first rises WIDTH*HEIGHT+1 cycles after the edge that sampled draw_start high in IDLE.
- Pixel order is raster: row-major, column fastest.
- Colour:
  - Solid (HOLLOW=0): always COLOUR.
  - Frame mode (HOLLOW=1): COLOUR when col==0, col==WIDTH-1, row==0 or row==HEIGHT-1; otherwise INTERIOR_COLOUR.
- DONE:
  - draw_done=1, x/y hold the last pixel, busy=0.
  - Stays in DONE while draw_start=1.
  - draw_start=0 → IDLE next cycle, draw_done=0.
- Abort: draw_start=0 while in DRAW → IDLE next cycle, draw_done never asserted, col/row cleared.
- Back-to-back: draw_start re-raised in the first IDLE cycle after DONE starts a full new scan.
- Move (only when SCROLL=1; with SCROLL=0, move is ignored and move_pending stays 0):
  - In IDLE or DONE: apply immediately, on the same edge that samples move.
  - In DRAW: set move_pending=1 so the origin never changes mid-scan. Apply on the cycle the block enters IDLE or DONE, then clear move_pending.
  - Multiple moves during one DRAW collapse into a single pending move.
  - Move applied on the same edge as a DONE→IDLE transition takes effect normally.
- Apply rule: if origin_x < SPEED then origin_x=START_X, else origin_x=origin_x-SPEED.
  - The comparison is unsigned; the wrap prevents underflow.
- y never changes after reset.

Test Plan:
- Solid WIDTH=2, HEIGHT=2, START_X=10, START_Y=20; raise draw_start →
  - pixels (10,20),(11,20),(10,21),(11,21), colour 3'b111;
  - draw_done rises 5 cycles after draw_start is sampled and holds for 10 cycles of draw_start=1;
  - draw_done drops one cycle after draw_start falls.
- HOLLOW=1, WIDTH=HEIGHT=3 → 9 pixels.
  - Only (col,row)=(1,1) carries INTERIOR_COLOUR 3'b000.
  - The other 8 carry COLOUR.
- SPEED=4, START_X=10:
  - Three move pulses in IDLE → origin_x 6, 2, then wrap to 10.
  - Next scan starts at x=10.
- Moves during DRAW:
  - Two move pulses mid-scan → x/y unchanged for the rest of the scan.
  - On entering DONE, origin_x decreases by exactly 4.
  - Next scan starts at the new origin_x.
- Abort:
  - Drop draw_start after 2 pixels of a 4-pixel scan → IDLE, draw_done stays 0.
  - Re-raise → scan restarts at col=row=0.
- Async reset mid-DRAW with origin_x=6:
  - Within the same cycle: draw_done=0, busy=0, x=START_X, move_pending cleared.
  - No pixel output until draw_start is sampled again after reset deasserts.
